// File: rtl/stdp_weight_bank.sv
// Synaptic weight store for the STDP stage: arms a synapse, mirrors the spike-pair
// count, then clamps and writes back the STDP result. Host port for init/inspection.
module stdp_weight_bank #(
    parameter int unsigned          NUM_SYN = 6,
    parameter int unsigned          ADDR_W  = 3,
    parameter int unsigned          W_WIDTH = 8,
    parameter logic [W_WIDTH-1:0]   W_INIT  = 8'h40,
    parameter logic [W_WIDTH-1:0]   W_MIN   = 8'h04,
    parameter logic [W_WIDTH-1:0]   W_MAX   = 8'hF0,
    parameter int unsigned          TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sel_valid,
    input  logic [ADDR_W-1:0]   syn_sel,
    output logic                sel_ready,
    input  logic                spk_pre,
    input  logic                spk_post,
    output logic [W_WIDTH-1:0]  weight_before,
    input  logic [W_WIDTH-1:0]  weight_in,
    output logic                upd_done,
    output logic                timeout,
    output logic                sel_err,
    output logic                spk_dropped,
    input  logic                host_we,
    input  logic [ADDR_W-1:0]   host_addr,
    input  logic [W_WIDTH-1:0]  host_wdata,
    output logic [W_WIDTH-1:0]  host_rdata,
    output logic                host_conflict
);

    localparam int unsigned       TMR_W     = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [ADDR_W:0]   NUM_SYN_W = (ADDR_W + 1)'(NUM_SYN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_WAIT,
        S_COMMIT
    } state_t;

    logic [W_WIDTH-1:0] mem [NUM_SYN];

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [W_WIDTH-1:0] wb_d;
    logic               upd_done_d, timeout_d, sel_err_d, dropped_d;
    logic               commit_we;
    logic               spike;
    logic               sel_in_range, host_in_range, host_hit, host_wr_ok;
    logic [W_WIDTH-1:0] clamped;

    assign spike         = spk_pre | spk_post;
    assign sel_in_range  = {1'b0, syn_sel} < NUM_SYN_W;
    assign host_in_range = {1'b0, host_addr} < NUM_SYN_W;
    assign host_hit      = host_we & host_in_range & commit_we & (idx_q == host_addr);
    assign host_wr_ok    = host_we & host_in_range & ~host_hit;

    always_comb begin
        clamped = weight_in;
        if (weight_in < W_MIN) clamped = W_MIN;
        if (weight_in > W_MAX) clamped = W_MAX;
    end

    // Next-state and pulse decode.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        tmr_d      = tmr_q;
        wb_d       = weight_before;
        upd_done_d = 1'b0;
        timeout_d  = 1'b0;
        sel_err_d  = 1'b0;
        dropped_d  = spk_dropped;
        commit_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sel_valid) begin
                    if (sel_in_range) begin
                        idx_d   = syn_sel;
                        wb_d    = mem[syn_sel];
                        cnt_d   = 2'd0;
                        tmr_d   = '0;
                        state_d = S_ARMED;
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end
            end
            S_ARMED: begin
                if (spike) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd1) state_d = S_WAIT;
                end
                // Pair completion on the final timer cycle still wins.
                if (state_d != S_WAIT) begin
                    if (tmr_q == TMR_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
            end
            S_WAIT: begin
                if (spike) dropped_d = 1'b1;
                state_d = S_COMMIT;
            end
            S_COMMIT: begin
                if (spike) dropped_d = 1'b1;
                commit_we  = 1'b1;
                upd_done_d = 1'b1;
                state_d    = S_IDLE;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            cnt_q         <= 2'd0;
            tmr_q         <= '0;
            weight_before <= '0;
            sel_ready     <= 1'b1;
            upd_done      <= 1'b0;
            timeout       <= 1'b0;
            sel_err       <= 1'b0;
            spk_dropped   <= 1'b0;
            host_conflict <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            tmr_q         <= tmr_d;
            weight_before <= wb_d;
            sel_ready     <= (state_d == S_IDLE);
            upd_done      <= upd_done_d;
            timeout       <= timeout_d;
            sel_err       <= sel_err_d;
            spk_dropped   <= dropped_d;
            host_conflict <= host_hit;
        end
    end

    // Weight array; host read returns contents before this edge's writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem        <= '{default: W_INIT};
            host_rdata <= '0;
        end else begin
            host_rdata <= host_in_range ? mem[host_addr] : '0;
            if (host_wr_ok) mem[host_addr] <= host_wdata;
            if (commit_we)  mem[idx_q]     <= clamped;
        end
    end

endmodule

// File: tb/tb_stdp_weight_bank.sv
// Scenario bench for stdp_weight_bank: directed cases plus randomized updates
// checked against a transaction-level weight model.
module tb_stdp_weight_bank;

    localparam int NUM_SYN = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel_valid;
    logic [2:0] syn_sel;
    logic       sel_ready;
    logic       spk_pre, spk_post;
    logic [7:0] weight_before;
    logic [7:0] weight_in;
    logic       upd_done, timeout, sel_err, spk_dropped;
    logic       host_we;
    logic [2:0] host_addr;
    logic [7:0] host_wdata;
    logic [7:0] host_rdata;
    logic       host_conflict;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] model_mem [NUM_SYN];

    always #5 clk = ~clk;

    stdp_weight_bank dut (
        .clk(clk), .rst(rst),
        .sel_valid(sel_valid), .syn_sel(syn_sel), .sel_ready(sel_ready),
        .spk_pre(spk_pre), .spk_post(spk_post),
        .weight_before(weight_before), .weight_in(weight_in),
        .upd_done(upd_done), .timeout(timeout), .sel_err(sel_err),
        .spk_dropped(spk_dropped),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .host_conflict(host_conflict)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] clamp_ref(input logic [7:0] v);
        if (v < 8'h04) return 8'h04;
        if (v > 8'hF0) return 8'hF0;
        return v;
    endfunction

    task automatic host_read(input int addr, output logic [7:0] data);
        host_we   = 1'b0;
        host_addr = 3'(addr);
        tick();
        data = host_rdata;
    endtask

    task automatic host_write(input int addr, input logic [7:0] data);
        host_we    = 1'b1;
        host_addr  = 3'(addr);
        host_wdata = data;
        tick();
        host_we    = 1'b0;
    endtask

    task automatic arm(input int syn);
        int n = 0;
        while (sel_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        n_checks++;
        if (sel_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL arm_ready: sel_ready=%b required 1", sel_ready);
        end
        sel_valid = 1'b1;
        syn_sel   = 3'(syn);
        tick();
        sel_valid = 1'b0;
    endtask

    // Arm syn, pre spike then post spike gap cycles later; report cycles from
    // second spike edge to upd_done (-1 if never) and weight_before while armed.
    task automatic drive_pair(input int syn, input int gap, input logic [7:0] win,
                              output int lat, output logic [7:0] wb_seen);
        arm(syn);
        wb_seen   = weight_before;
        weight_in = win;
        spk_pre   = 1'b1;
        tick();
        spk_pre   = 1'b0;
        repeat (gap - 1) tick();
        spk_post  = 1'b1;
        tick();
        spk_post  = 1'b0;
        lat = -1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (upd_done === 1'b1 && lat < 0) lat = k;
        end
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (sel_ready !== 1'b1) begin n_fail++; $display("FAIL reset_sel_ready: got %b required 1", sel_ready); end
        n_checks++;
        if (weight_before !== 8'h00) begin n_fail++; $display("FAIL reset_weight_before: got %h required 00", weight_before); end
        n_checks++;
        if ({upd_done, timeout, sel_err, spk_dropped, host_conflict} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 00000", {upd_done, timeout, sel_err, spk_dropped, host_conflict});
        end
        n_checks++;
        if (host_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h required 00", host_rdata); end
        rst = 1'b0;
        for (int a = 0; a < NUM_SYN; a++) model_mem[a] = 8'h40;
        for (int a = 0; a < NUM_SYN; a++) begin
            host_read(a, rd);
            n_checks++;
            if (rd !== model_mem[a]) begin n_fail++; $display("FAIL reset_mem[%0d]: got %h required %h", a, rd, model_mem[a]); end
        end
    endtask

    task automatic test_basic_update();
        int lat;
        logic [7:0] wb, rd;
        drive_pair(2, 3, 8'h55, lat, wb);
        n_checks++;
        if (wb !== 8'h40) begin n_fail++; $display("FAIL basic_weight_before: got %h required 40", wb); end
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL basic_latency: got %0d required 2", lat); end
        model_mem[2] = clamp_ref(8'h55);
        host_read(2, rd);
        n_checks++;
        if (rd !== model_mem[2]) begin n_fail++; $display("FAIL basic_mem2: got %h required %h", rd, model_mem[2]); end
        n_checks++;
        if (sel_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b required 1", sel_ready); end
    endtask

    task automatic test_clamp();
        int lat;
        logic [7:0] wb, rd;
        drive_pair(1, 1, 8'hFF, lat, wb);
        model_mem[1] = clamp_ref(8'hFF);
        host_read(1, rd);
        n_checks++;
        if (rd !== 8'hF0 || lat !== 2) begin n_fail++; $display("FAIL clamp_high: got %h lat %0d required F0 lat 2", rd, lat); end
        drive_pair(1, 2, 8'h01, lat, wb);
        n_checks++;
        if (wb !== model_mem[1]) begin n_fail++; $display("FAIL clamp_wb: got %h required %h", wb, model_mem[1]); end
        model_mem[1] = clamp_ref(8'h01);
        host_read(1, rd);
        n_checks++;
        if (rd !== 8'h04 || lat !== 2) begin n_fail++; $display("FAIL clamp_low: got %h lat %0d required 04 lat 2", rd, lat); end
    endtask

    task automatic test_timeout();
        int n_to = -1;
        logic seen_upd = 1'b0;
        logic [7:0] rd;
        arm(3);
        weight_in = 8'h99;
        spk_pre = 1'b1;
        tick();
        spk_pre = 1'b0;
        for (int n = 2; n <= 100; n++) begin
            tick();
            if (upd_done === 1'b1) seen_upd = 1'b1;
            if (timeout === 1'b1) begin n_to = n; break; end
        end
        n_checks++;
        if (n_to !== 64) begin n_fail++; $display("FAIL timeout_cycle: got %0d required 64", n_to); end
        n_checks++;
        if (sel_ready !== 1'b1) begin n_fail++; $display("FAIL timeout_ready: got %b required 1", sel_ready); end
        tick();
        n_checks++;
        if (timeout !== 1'b0 || seen_upd !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pulse: timeout=%b upd_seen=%b required 0 0", timeout, seen_upd);
        end
        host_read(3, rd);
        n_checks++;
        if (rd !== model_mem[3]) begin n_fail++; $display("FAIL timeout_mem3: got %h required %h", rd, model_mem[3]); end
    endtask

    task automatic test_simul_spike();
        logic [7:0] rd, win;
        logic upd_at_2;
        win = 8'($urandom);
        arm(4);
        weight_in = win;
        spk_pre = 1'b1; spk_post = 1'b1;
        tick();
        spk_pre = 1'b0;
        tick();
        spk_post = 1'b0;
        n_checks++;
        if (spk_dropped !== 1'b0) begin n_fail++; $display("FAIL drop_early: got %b required 0", spk_dropped); end
        spk_pre = 1'b1;
        tick();
        spk_pre = 1'b0;
        n_checks++;
        if (spk_dropped !== 1'b1) begin n_fail++; $display("FAIL drop_in_wait: got %b required 1", spk_dropped); end
        tick();
        upd_at_2 = upd_done;
        n_checks++;
        if (upd_at_2 !== 1'b1) begin n_fail++; $display("FAIL simul_upd: got %b required 1", upd_at_2); end
        model_mem[4] = clamp_ref(win);
        host_read(4, rd);
        n_checks++;
        if (rd !== model_mem[4]) begin n_fail++; $display("FAIL simul_mem4: got %h required %h", rd, model_mem[4]); end
        n_checks++;
        if (spk_dropped !== 1'b1) begin n_fail++; $display("FAIL drop_sticky: got %b required 1", spk_dropped); end
    endtask

    task automatic test_conflict();
        logic [7:0] rd;
        arm(0);
        weight_in = 8'h70;
        spk_pre = 1'b1;
        tick();
        spk_pre = 1'b0; spk_post = 1'b1;
        tick();
        spk_post = 1'b0;
        tick();
        host_we = 1'b1; host_addr = 3'd0; host_wdata = 8'h22;
        tick();
        host_we = 1'b0;
        n_checks++;
        if (upd_done !== 1'b1 || host_conflict !== 1'b1) begin
            n_fail++;
            $display("FAIL conflict_pulse: upd=%b conflict=%b required 1 1", upd_done, host_conflict);
        end
        model_mem[0] = clamp_ref(8'h70);
        host_read(0, rd);
        n_checks++;
        if (host_conflict !== 1'b0) begin n_fail++; $display("FAIL conflict_one_cycle: got %b required 0", host_conflict); end
        n_checks++;
        if (rd !== model_mem[0]) begin n_fail++; $display("FAIL conflict_mem0: got %h required %h", rd, model_mem[0]); end
    endtask

    task automatic test_sel_err();
        for (int s = 6; s <= 7; s++) begin
            sel_valid = 1'b1;
            syn_sel = 3'(s);
            tick();
            sel_valid = 1'b0;
            n_checks++;
            if (sel_err !== 1'b1 || sel_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL sel_err_%0d: err=%b ready=%b required 1 1", s, sel_err, sel_ready);
            end
            tick();
            n_checks++;
            if (sel_err !== 1'b0) begin n_fail++; $display("FAIL sel_err_clear_%0d: got %b required 0", s, sel_err); end
        end
    endtask

    task automatic test_host();
        logic [7:0] v, rd;
        v = 8'($urandom);
        host_we = 1'b1; host_addr = 3'd5; host_wdata = v;
        tick();
        host_we = 1'b0;
        n_checks++;
        if (host_rdata !== model_mem[5]) begin n_fail++; $display("FAIL host_rbw: got %h required %h", host_rdata, model_mem[5]); end
        model_mem[5] = v;
        host_read(5, rd);
        n_checks++;
        if (rd !== v) begin n_fail++; $display("FAIL host_write: got %h required %h", rd, v); end
        host_write(7, 8'hAB);
        host_read(7, rd);
        n_checks++;
        if (rd !== 8'h00) begin n_fail++; $display("FAIL host_oob_read: got %h required 00", rd); end
        for (int a = 0; a < NUM_SYN; a++) begin
            host_read(a, rd);
            n_checks++;
            if (rd !== model_mem[a]) begin n_fail++; $display("FAIL host_oob_mem[%0d]: got %h required %h", a, rd, model_mem[a]); end
        end
    endtask

    task automatic test_random();
        int syn, gap, lat, ha;
        logic [7:0] win, hv, wb, rd;
        for (int it = 0; it < 20; it++) begin
            if ($urandom_range(1, 0) == 1) begin
                ha = $urandom_range(NUM_SYN - 1, 0);
                hv = 8'($urandom);
                host_write(ha, hv);
                model_mem[ha] = hv;
            end
            syn = $urandom_range(NUM_SYN - 1, 0);
            gap = $urandom_range(5, 1);
            win = 8'($urandom);
            drive_pair(syn, gap, win, lat, wb);
            n_checks++;
            if (wb !== model_mem[syn]) begin n_fail++; $display("FAIL rand_wb it%0d syn%0d: got %h required %h", it, syn, wb, model_mem[syn]); end
            n_checks++;
            if (lat !== 2) begin n_fail++; $display("FAIL rand_lat it%0d: got %0d required 2", it, lat); end
            model_mem[syn] = clamp_ref(win);
            host_read(syn, rd);
            n_checks++;
            if (rd !== model_mem[syn]) begin n_fail++; $display("FAIL rand_mem it%0d syn%0d: got %h required %h", it, syn, rd, model_mem[syn]); end
        end
    endtask

    task automatic test_reset_mid();
        logic seen_upd = 1'b0;
        logic [7:0] rd;
        arm(5);
        weight_in = 8'h88;
        spk_pre = 1'b1;
        tick();
        spk_pre = 1'b0; spk_post = 1'b1;
        tick();
        spk_post = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int a = 0; a < NUM_SYN; a++) model_mem[a] = 8'h40;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (upd_done === 1'b1) seen_upd = 1'b1;
        end
        n_checks++;
        if (seen_upd !== 1'b0 || sel_ready !== 1'b1 || spk_dropped !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: upd_seen=%b ready=%b dropped=%b required 0 1 0", seen_upd, sel_ready, spk_dropped);
        end
        host_read(5, rd);
        n_checks++;
        if (rd !== model_mem[5]) begin n_fail++; $display("FAIL reset_mid_mem5: got %h required %h", rd, model_mem[5]); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sel_valid = 1'b0; syn_sel = '0;
        spk_pre = 1'b0; spk_post = 1'b0; weight_in = '0;
        host_we = 1'b0; host_addr = '0; host_wdata = '0;
        test_reset();
        test_basic_update();
        test_clamp();
        test_timeout();
        test_simul_spike();
        test_conflict();
        test_sel_err();
        test_host();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
